// File: rtl/mx_pkg.sv
// Shared definitions for the MX block serialiser.
//   MX_EXP_W          shared-exponent width
//   HDR_EXP_LSB/MSB   position of the exponent inside a header beat; the
//                     remaining header bits are always zero
//   ser_state_t       serialiser FSM states
//   beats_per_block() header beat plus k/lanes element beats
package mx_pkg;

  localparam int MX_EXP_W    = 8;
  localparam int HDR_EXP_LSB = 0;
  localparam int HDR_EXP_MSB = HDR_EXP_LSB + MX_EXP_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } ser_state_t;

  function automatic int beats_per_block(input int k, input int lanes);
    return 1 + k / lanes;
  endfunction

endpackage

// File: rtl/mx_block_serialiser.sv
// mx_block_serialiser
//   Takes one MX block (k signed elements + shared exponent) per handshake
//   and streams it as one header beat followed by k/lanes element beats.
//   An active slot feeds the output while a pending slot holds the next
//   block, so consecutive blocks stream without idle beats.
//
// Ports
//   i_clk, i_rst_n     clock, async active-low reset
//   i_valid / o_ready  block handshake; o_ready depends only on registers
//   i_mx_vec, i_mx_exp block elements (element 0 first) and exponent
//   o_valid / i_ready  beat handshake
//   o_data             beat payload, lanes*bit_width bits
//   o_last             final element beat flag (only with MX_SER_LAST_EN)
//
// Build option: define MX_SER_LAST_EN to add the o_last port.
module mx_block_serialiser
  import mx_pkg::*;
#(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [bit_width-1:0]         i_mx_vec [k],
  input  logic [MX_EXP_W-1:0]          i_mx_exp,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [lanes*bit_width-1:0]   o_data
`ifdef MX_SER_LAST_EN
  ,
  output logic                         o_last
`endif
);

  localparam int W  = lanes * bit_width;
  localparam int NB = beats_per_block(k, lanes) - 1;  // element beats
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST_B = CW'(NB);

  if ((k % lanes) != 0) begin : g_k_check
    $error("mx_block_serialiser: k (%0d) must be a multiple of lanes (%0d)", k, lanes);
  end
  if (W < MX_EXP_W) begin : g_w_check
    $error("mx_block_serialiser: beat width %0d cannot hold the exponent", W);
  end

  typedef struct packed {
    logic [MX_EXP_W-1:0]             exp;
    logic [k-1:0][bit_width-1:0]     vec;
  } slot_t;

  slot_t      act_q, pnd_q, in_slot;
  logic       pnd_full_q;
  ser_state_t state_q, state_d;
  logic [CW-1:0] beat_q, beat_d;

  logic accept, fire, last_fire, load_act, load_pnd, promote;

  always_comb begin
    in_slot     = '0;
    in_slot.exp = i_mx_exp;
    for (int i = 0; i < k; i++) in_slot.vec[i] = i_mx_vec[i];
  end

  assign o_ready   = !pnd_full_q;
  assign accept    = i_valid && o_ready;
  assign o_valid   = (state_q != IDLE);
  assign fire      = o_valid && i_ready;
  assign last_fire = fire && (state_q == DATA) && (beat_q == LAST_B);
  // A block arriving while the active slot is empty or just finishing goes
  // straight to active; otherwise it waits in pending.
  assign load_act  = accept && ((state_q == IDLE) || last_fire);
  assign load_pnd  = accept && !load_act;
  assign promote   = last_fire && pnd_full_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: if (accept) state_d = HDR;
      HDR: begin
        if (fire) begin
          state_d = DATA;
          beat_d  = CW'(1);
        end
      end
      DATA: begin
        if (fire) begin
          if (beat_q == LAST_B) begin
            beat_d  = '0;
            state_d = (pnd_full_q || accept) ? HDR : IDLE;
          end else begin
            beat_d  = beat_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      act_q      <= '0;
      pnd_q      <= '0;
      pnd_full_q <= 1'b0;
    end else begin
      if (load_act)     act_q <= in_slot;
      else if (promote) act_q <= pnd_q;

      if (load_pnd) begin
        pnd_q      <= in_slot;
        pnd_full_q <= 1'b1;
      end else if (promote) begin
        pnd_full_q <= 1'b0;
      end
    end
  end

  // Payload is a pure decode of registered state, so it holds while stalled.
  always_comb begin
    o_data = '0;
    unique case (state_q)
      HDR: o_data[HDR_EXP_MSB:HDR_EXP_LSB] = act_q.exp;
      DATA: begin
        for (int bb = 1; bb <= NB; bb++) begin
          if (beat_q == CW'(bb)) begin
            for (int j = 0; j < lanes; j++)
              o_data[j*bit_width +: bit_width] = act_q.vec[(bb-1)*lanes + j];
          end
        end
      end
      default: o_data = '0;
    endcase
  end

`ifdef MX_SER_LAST_EN
  assign o_last = (state_q == DATA) && (beat_q == LAST_B);
`endif

endmodule

// File: tb/tb_mx_block_serialiser.sv
module tb_mx_block_serialiser;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  i_mx_vec [32];
  logic [7:0]  i_mx_exp = 8'h00;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [63:0] o_data;
`ifdef MX_SER_LAST_EN
  logic        o_last;
`endif

  int checks = 0;
  int errors = 0;
  bit tog = 1'b0;
  bit rec = 1'b0;
  int cyc = 0;

  logic [63:0] q [$];
  int          cq [$];
  logic        lq [$];
  logic [63:0] held;
  bit          held_v = 1'b0;

  logic [7:0] bases [3];
  logic [7:0] exps  [3];

  mx_block_serialiser dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_mx_vec(i_mx_vec), .i_mx_exp(i_mx_exp), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data)
`ifdef MX_SER_LAST_EN
    , .o_last(o_last)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Beat n of a stream built from blocks 0,1,2 in order.
  function automatic logic [63:0] model(input int n);
    logic [63:0] r;
    int blk, pos;
    blk = n / 5;
    pos = n % 5;
    r = '0;
    if (pos == 0) r[7:0] = exps[blk];
    else for (int j = 0; j < 8; j++) r[j*8 +: 8] = 8'(int'(bases[blk]) + (pos-1)*8 + j);
    return r;
  endfunction

  function automatic logic [63:0] hdr(input int blk);
    return {56'd0, exps[blk]};
  endfunction

  // Monitor: records transfers and checks that a stalled beat holds.
  always @(negedge i_clk) begin
    if (held_v && i_rst_n) begin
      checks++;
      assert (o_data === held) else begin
        errors++;
        $error("FAIL stall_hold observed=%h expected=%h", o_data, held);
      end
    end
    held_v = o_valid && !i_ready && i_rst_n;
    held   = o_data;
    if (rec && o_valid && i_ready) begin
      q.push_back(o_data);
      cq.push_back(cyc);
`ifdef MX_SER_LAST_EN
      lq.push_back(o_last);
`endif
    end
    cyc++;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
    if (tog) i_ready = !i_ready;
  endtask

  task automatic set_blk(input int idx);
    for (int i = 0; i < 32; i++) i_mx_vec[i] = 8'(int'(bases[idx]) + i);
    i_mx_exp = exps[idx];
  endtask

  task automatic send(input int idx);
    bit acc;
    acc = 1'b0;
    set_blk(idx);
    i_valid = 1'b1;
    for (int n = 0; n < 60 && !acc; n++) begin
      if (o_ready) acc = 1'b1;
      step();
    end
    i_valid = 1'b0;
    chk($sformatf("send_accept_%0d", idx), {63'd0, acc}, 64'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && o_valid; n++) step();
    chk("drain_idle", {63'd0, o_valid}, 64'd0);
  endtask

  task automatic start_rec();
    q.delete();
    cq.delete();
    lq.delete();
    rec = 1'b1;
  endtask

  task automatic check_stream(input int nblk);
    rec = 1'b0;
    chk("beat_count", 64'(q.size()), 64'(nblk * 5));
    for (int i = 0; i < q.size() && i < nblk * 5; i++) begin
      chk($sformatf("beat%0d", i), q[i], model(i));
`ifdef MX_SER_LAST_EN
      chk($sformatf("last%0d", i), {63'd0, lq[i]}, {63'd0, (i % 5) == 4});
`endif
    end
  endtask

  initial begin
    bases[0] = 8'h00; exps[0] = 8'h85;
    bases[1] = 8'h40; exps[1] = 8'h86;
    bases[2] = 8'h80; exps[2] = 8'h87;
    set_blk(0);

    // Reset
    #1 i_rst_n = 1'b0;
    #2;
    chk("rst_valid", {63'd0, o_valid}, 64'd0);
    chk("rst_data", o_data, 64'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    chk("rel_ready", {63'd0, o_ready}, 64'd1);
    chk("rel_valid", {63'd0, o_valid}, 64'd0);

    // Single block, hand-computed beats
    i_ready = 1'b1;
    set_blk(0);
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    chk("s_hdr", o_data, 64'h0000000000000085);
    chk("s_hdr_v", {63'd0, o_valid}, 64'd1);
    step(); chk("s_b1", o_data, 64'h0706050403020100);
    step(); chk("s_b2", o_data, 64'h0F0E0D0C0B0A0908);
    step(); chk("s_b3", o_data, 64'h1716151413121110);
`ifdef MX_SER_LAST_EN
    chk("s_last3", {63'd0, o_last}, 64'd0);
`endif
    step(); chk("s_b4", o_data, 64'h1F1E1D1C1B1A1918);
`ifdef MX_SER_LAST_EN
    chk("s_last4", {63'd0, o_last}, 64'd1);
`endif
    step(); chk("s_end_v", {63'd0, o_valid}, 64'd0);

    // Back-to-back: 15 beats with no gaps
    start_rec();
    send(0); send(1); send(2);
    drain();
    check_stream(3);
    for (int i = 1; i < cq.size(); i++)
      chk($sformatf("gap%0d", i), 64'(cq[i] - cq[i-1]), 64'd1);

    // Backpressure: i_ready toggling, same stream
    i_ready = 1'b1;
    tog = 1'b1;
    start_rec();
    send(0); send(1); send(2);
    drain();
    tog = 1'b0;
    check_stream(3);

    // Pending full
    i_ready = 1'b0;
    send(0);
    send(1);
    set_blk(2);
    i_valid = 1'b1;
    chk("pf_ready0", {63'd0, o_ready}, 64'd0);
    step(); step(); step();
    chk("pf_ready0b", {63'd0, o_ready}, 64'd0);
    chk("pf_hold_hdr", o_data, hdr(0));
    i_valid = 1'b0;
    start_rec();
    i_ready = 1'b1;
    step(); step(); step(); step();
    chk("pf_ready_lastA", {63'd0, o_ready}, 64'd0);
    step();
    chk("pf_ready_back", {63'd0, o_ready}, 64'd1);
    chk("pf_hdrB", o_data, hdr(1));
    drain();
    check_stream(2);

    // Simultaneous accept on last beat
    i_ready = 1'b1;
    send(0);
    step(); step(); step(); step();
    chk("sim_b4", o_data, model(4));
    set_blk(1);
    i_valid = 1'b1;
    chk("sim_ready", {63'd0, o_ready}, 64'd1);
    step();
    i_valid = 1'b0;
    chk("sim_valid", {63'd0, o_valid}, 64'd1);
    chk("sim_hdrB", o_data, hdr(1));
    chk("sim_ready2", {63'd0, o_ready}, 64'd1);
    drain();

    // Mid-block reset
    send(0);
    step(); step();
    chk("mr_b2", o_data, model(2));
    i_rst_n = 1'b0;
    #1;
    chk("mr_valid", {63'd0, o_valid}, 64'd0);
    chk("mr_data", o_data, 64'd0);
    step();
    i_rst_n = 1'b1;
    step();
    chk("mr_no_resume", {63'd0, o_valid}, 64'd0);
    send(2);
    chk("mr_hdrC", o_data, hdr(2));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mx_block_serialiser.md
Name: mx_block_serialiser

Overview:
- Downstream of the bf16-to-MXINT converter.
- Accepts one MX block per valid/ready handshake: k signed bit_width-bit elements plus an 8-bit shared exponent.
- Streams the block onto a narrow valid/ready word bus: one header beat carrying the exponent, then k/lanes element beats.
- Double-buffered (active slot plus pending slot), so back-to-back blocks stream with no idle beats.

Parameters:
- bit_width, 8, element width in bits.
- k, 32, elements per MX block; must be a multiple of lanes, otherwise elaboration fails with $error.
- lanes, 8, elements per output beat; output word width W = lanes*bit_width.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream block valid.
- o_ready  output  1  block accepted when i_valid && o_ready.
- i_mx_vec  input  bit_width x k (unpacked array [k])  block elements, element 0 first.
- i_mx_exp  input  8  shared exponent.
- o_valid  output  1  output beat valid.
- i_ready  input  1  downstream ready; beat transfers when o_valid && i_ready.
- o_data  output  W  beat payload.
- o_last  output  1  final beat of a block (only with MX_SER_LAST_EN).

Behaviour:
- Reset (async assert, sync release): o_valid=0, o_data=0, o_last=0, both slots empty, beat counter=0, FSM=IDLE. o_ready reads 1 once reset releases.
- o_ready = !pending_full, a pure register decode. There is no combinational path from i_ready to o_ready.
- Accept: if active is empty, or active transfers its final beat in the same cycle, the block loads into active. Otherwise it loads into pending.
- Active completes while pending is full: pending moves to active on that edge and pending clears.
- FSM states:
  - IDLE: active empty, o_valid=0.
  - HDR: o_valid=1, o_data[7:0]=exp, o_data[W-1:8]=0.
  - DATA: beat counter b = 1..k/lanes.
- Transitions:
  - IDLE->HDR on load.
  - HDR->DATA on transfer.
  - DATA b->b+1 on transfer.
  - DATA last beat: transfer goes to HDR if a block is available (pending or same-cycle accept), else to IDLE.
- DATA beat b payload: element (b-1)*lanes+j at o_data[j*bit_width +: bit_width], j=0..lanes-1, raw two's-complement bits.
- Latency: a block accepted at edge t presents its header from cycle t+1.
- Throughput: 1+k/lanes beats per block, sustained with zero bubbles while i_ready=1.
- Output stability: while o_valid && !i_ready, o_data, o_last and the state hold stable.
- Beats per block = 1+k/lanes, exactly 5 with defaults.
- A reset asserted mid-block discards both slots immediately. No partial block is resumed after release.
- i_valid is ignored while o_ready=0. Upstream holds the block until accepted.

Optional Feature:
- Macro MX_SER_LAST_EN.
- When defined: port o_last exists; it is 1 exactly on the final DATA beat of each block and 0 on header and other beats.
- When undefined: the port is absent and framing is implied by the fixed beat count.
- Serialisation timing is identical in both builds.

Decomposition:
- Shared package mx_pkg:
  - MX_EXP_W=8
  - header field constants (exponent at bits [7:0], remaining bits zero)
  - state enum ser_state_t {IDLE,HDR,DATA}
  - function beats_per_block(k,lanes).
- Slot storage is a single registered struct {exp, vec} instanced twice.
- No sub-module is warranted; the block is one module.

Test Plan:
- Single block: exp=0x85, element i=i, i_ready=1 -> header 0x...0085 at t+1, then beats 0x0706050403020100, 0x0F0E0D0C0B0A0908, etc.; o_last on beat 5 only.
- Back-to-back: 3 blocks with i_valid held high, i_ready=1 -> 15 consecutive valid beats, no gaps, headers at beats 0/5/10.
- Backpressure: i_ready toggling 1010... -> every beat held stable while stalled; the output sequence is identical to the unstalled run.
- Pending full: i_ready=0 with 2 blocks accepted -> o_ready=0 and a third i_valid is not accepted; raising i_ready drains in order A then B, and o_ready returns to 1 the cycle after A's last beat.
- Simultaneous: a new block is presented on the cycle active's last beat transfers with pending empty -> next cycle shows the new header, o_ready stays 1.
- Mid-block reset: assert i_rst_n=0 at DATA beat 2 -> o_valid=0 immediately; after release the next accepted block starts with a header beat.
